axi_user_addr_remapper: RTL and testbench



---
 rtl/addr_remap_pkg.sv | 37 +++
 rtl/axi_addr_slice.sv | 82 ++++++++
 rtl/axi_user_addr_remapper.sv | 146 ++++++++++++++
 tb/tb_axi_user_addr_remapper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_remap_pkg.sv
// Shared types for the DSID-indexed AXI address remapper: cfg field selects,
// table entry layout, skid-slice states and the remap function itself.
package addr_remap_pkg;

  // Entries are stored at the widest supported address; users truncate.
  localparam int MAX_ADDR_W = 64;

  localparam logic [1:0] SEL_BASE  = 2'd0;
  localparam logic [1:0] SEL_MASK  = 2'd1;
  localparam logic [1:0] SEL_VALID = 2'd2;
  localparam logic [1:0] SEL_CLR   = 2'd3;

  localparam int CH_AW = 0;
  localparam int CH_AR = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] base;
    logic [MAX_ADDR_W-1:0] mask;
  } remap_entry_t;

  localparam remap_entry_t ENTRY_RESET = '{valid: 1'b0, base: '0, mask: '1};

  function automatic logic [MAX_ADDR_W-1:0] remap_addr(
    input remap_entry_t          e,
    input logic [MAX_ADDR_W-1:0] addr
  );
    return e.valid ? (e.base + (addr & e.mask)) : addr;
  endfunction

endpackage

// File: rtl/axi_addr_slice.sv
// Two-entry registered skid slice: full throughput, s_ready driven from a flop
// so there is no combinational path from m_ready back to s_ready.
module axi_addr_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  import addr_remap_pkg::*;

  slice_state_t state_reg, state_next;
  logic         s_ready_reg;
  logic [W-1:0] main_reg, skid_reg;
  logic         load_main_in, load_main_skid, load_skid_in;
  logic         accept, take;

  assign s_ready = s_ready_reg;
  assign m_valid = (state_reg != EMPTY);
  assign m_data  = main_reg;
  assign accept  = s_valid & s_ready_reg;
  assign take    = m_valid & m_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_main_in = 1'b1;
        end else if (take) begin
          state_next = EMPTY;
        end else if (accept) begin
          state_next   = FULL;
          load_skid_in = 1'b1;
        end
      end
      FULL: begin
        // s_ready is low here, so only a downstream take can happen
        if (take) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= EMPTY;
      s_ready_reg <= 1'b0;
      main_reg    <= '0;
      skid_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      s_ready_reg <= (state_next != FULL);
      if (load_main_in) begin
        main_reg <= s_data;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid_in) begin
        skid_reg <= s_data;
      end
    end
  end

endmodule

// File: rtl/axi_user_addr_remapper.sv
// AW/AR address remapper indexed by awuser/aruser (DSID) through a shared
// runtime table. Hit counters are built when AXI_USER_ADDR_REMAPPER_STATS_EN is defined.
module axi_user_addr_remapper
  import addr_remap_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int USER_W    = 16,
  parameter  int N_ENTRIES = 4,
  parameter  int PAYLOAD_W = 32,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_wen,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [1:0]           cfg_sel,
  input  logic [ADDR_W-1:0]    cfg_wdata,
  input  logic                 s_aw_valid,
  output logic                 s_aw_ready,
  input  logic [ADDR_W-1:0]    s_aw_addr,
  input  logic [USER_W-1:0]    s_aw_user,
  input  logic [PAYLOAD_W-1:0] s_aw_payload,
  output logic                 m_aw_valid,
  input  logic                 m_aw_ready,
  output logic [ADDR_W-1:0]    m_aw_addr,
  output logic [USER_W-1:0]    m_aw_user,
  output logic [PAYLOAD_W-1:0] m_aw_payload,
  input  logic                 s_ar_valid,
  output logic                 s_ar_ready,
  input  logic [ADDR_W-1:0]    s_ar_addr,
  input  logic [USER_W-1:0]    s_ar_user,
  input  logic [PAYLOAD_W-1:0] s_ar_payload,
  output logic                 m_ar_valid,
  input  logic                 m_ar_ready,
  output logic [ADDR_W-1:0]    m_ar_addr,
  output logic [USER_W-1:0]    m_ar_user,
  output logic [PAYLOAD_W-1:0] m_ar_payload
`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
  ,
  output logic [31:0]          aw_hit_cnt,
  output logic [31:0]          ar_hit_cnt
`endif
);

  localparam int DATA_W = ADDR_W + USER_W + PAYLOAD_W;

  remap_entry_t table_v [N_ENTRIES];

  logic [1:0]           s_valid_v, s_ready_v, m_valid_v, m_ready_v;
  logic [ADDR_W-1:0]    s_addr_v    [2];
  logic [USER_W-1:0]    s_user_v    [2];
  logic [PAYLOAD_W-1:0] s_payload_v [2];
  logic [DATA_W-1:0]    m_data_v    [2];

  assign s_valid_v             = {s_ar_valid, s_aw_valid};
  assign m_ready_v             = {m_ar_ready, m_aw_ready};
  assign s_addr_v[CH_AW]       = s_aw_addr;
  assign s_addr_v[CH_AR]       = s_ar_addr;
  assign s_user_v[CH_AW]       = s_aw_user;
  assign s_user_v[CH_AR]       = s_ar_user;
  assign s_payload_v[CH_AW]    = s_aw_payload;
  assign s_payload_v[CH_AR]    = s_ar_payload;

  assign s_aw_ready = s_ready_v[CH_AW];
  assign s_ar_ready = s_ready_v[CH_AR];
  assign m_aw_valid = m_valid_v[CH_AW];
  assign m_ar_valid = m_valid_v[CH_AR];
  assign {m_aw_addr, m_aw_user, m_aw_payload} = m_data_v[CH_AW];
  assign {m_ar_addr, m_ar_user, m_ar_payload} = m_data_v[CH_AR];

  genvar gi;

  // Remap table: one register per entry, shared by AW and AR
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      remap_entry_t entry_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          entry_reg <= ENTRY_RESET;
        end else if (cfg_wen && (cfg_idx == IDX_W'(gi))) begin
          case (cfg_sel)
            SEL_BASE:  entry_reg.base  <= MAX_ADDR_W'(cfg_wdata);
            SEL_MASK:  entry_reg.mask  <= MAX_ADDR_W'(cfg_wdata);
            SEL_VALID: entry_reg.valid <= cfg_wdata[0];
            default:   ;
          endcase
        end
      end

      assign table_v[gi] = entry_reg;
    end
  endgenerate

`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
  logic [31:0] hit_cnt_v [2];
  logic        stats_clr;

  assign stats_clr  = cfg_wen && (cfg_sel == SEL_CLR);
  assign aw_hit_cnt = hit_cnt_v[CH_AW];
  assign ar_hit_cnt = hit_cnt_v[CH_AR];
`endif

  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      remap_entry_t          entry;
      logic [MAX_ADDR_W-1:0] remapped_full;
      logic                  unused_remap_hi;

      // Lookup happens on the accepting cycle, so a same-cycle cfg write is not seen
      assign entry           = table_v[s_user_v[gi][IDX_W-1:0]];
      assign remapped_full   = remap_addr(entry, MAX_ADDR_W'(s_addr_v[gi]));
      assign unused_remap_hi = ^remapped_full;

      axi_addr_slice #(
        .W (DATA_W)
      ) u_slice (
        .clock   (clock),
        .reset   (reset),
        .s_valid (s_valid_v[gi]),
        .s_ready (s_ready_v[gi]),
        .s_data  ({remapped_full[ADDR_W-1:0], s_user_v[gi], s_payload_v[gi]}),
        .m_valid (m_valid_v[gi]),
        .m_ready (m_ready_v[gi]),
        .m_data  (m_data_v[gi])
      );

`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
      logic [31:0] hit_cnt_reg;
      logic        hit;

      assign hit           = s_valid_v[gi] & s_ready_v[gi] & entry.valid;
      assign hit_cnt_v[gi] = hit_cnt_reg;

      always_ff @(posedge clock) begin
        if (reset || stats_clr) begin
          hit_cnt_reg <= '0;
        end else if (hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
          hit_cnt_reg <= hit_cnt_reg + 32'd1;
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_axi_user_addr_remapper.sv
// Directed bench for axi_user_addr_remapper; stats checks are compiled in
// when AXI_USER_ADDR_REMAPPER_STATS_EN is defined.
module tb_axi_user_addr_remapper;

  logic        clock;
  logic        reset;
  logic        cfg_wen;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic [31:0] s_aw_addr, m_aw_addr, s_aw_payload, m_aw_payload;
  logic [15:0] s_aw_user, m_aw_user;
  logic        s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [31:0] s_ar_addr, m_ar_addr, s_ar_payload, m_ar_payload;
  logic [15:0] s_ar_user, m_ar_user;
`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
  logic [31:0] aw_hit_cnt, ar_hit_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  axi_user_addr_remapper dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_wen      (cfg_wen),
    .cfg_idx      (cfg_idx),
    .cfg_sel      (cfg_sel),
    .cfg_wdata    (cfg_wdata),
    .s_aw_valid   (s_aw_valid),
    .s_aw_ready   (s_aw_ready),
    .s_aw_addr    (s_aw_addr),
    .s_aw_user    (s_aw_user),
    .s_aw_payload (s_aw_payload),
    .m_aw_valid   (m_aw_valid),
    .m_aw_ready   (m_aw_ready),
    .m_aw_addr    (m_aw_addr),
    .m_aw_user    (m_aw_user),
    .m_aw_payload (m_aw_payload),
    .s_ar_valid   (s_ar_valid),
    .s_ar_ready   (s_ar_ready),
    .s_ar_addr    (s_ar_addr),
    .s_ar_user    (s_ar_user),
    .s_ar_payload (s_ar_payload),
    .m_ar_valid   (m_ar_valid),
    .m_ar_ready   (m_ar_ready),
    .m_ar_addr    (m_ar_addr),
    .m_ar_user    (m_ar_user),
    .m_ar_payload (m_ar_payload)
`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
    ,
    .aw_hit_cnt   (aw_hit_cnt),
    .ar_hit_cnt   (ar_hit_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] data);
    cfg_wen   = 1'b1;
    cfg_idx   = idx;
    cfg_sel   = sel;
    cfg_wdata = data;
    cyc();
    cfg_wen   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] ar_users [7];

  initial begin
    reset = 1'b1;
    cfg_wen = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    s_aw_valid = 1'b0; s_aw_addr = '0; s_aw_user = '0; s_aw_payload = '0; m_aw_ready = 1'b1;
    s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_user = '0; s_ar_payload = '0; m_ar_ready = 1'b1;

    // Reset state
    cyc(); cyc();
    chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_s_aw_ready", 64'(s_aw_ready), 64'd0);
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("rst_m_aw_addr",  64'(m_aw_addr),  64'd0);
    chk("rst_m_ar_payload", 64'(m_ar_payload), 64'd0);
    reset = 1'b0;
    cyc();
    chk("post_rst_s_aw_ready", 64'(s_aw_ready), 64'd1);
    chk("post_rst_s_ar_ready", 64'(s_ar_ready), 64'd1);

    // Unmapped pass-through
    s_aw_valid = 1'b1; s_aw_addr = 32'h8000_1000; s_aw_user = 16'h0002; s_aw_payload = 32'hA5A5_0001;
    cyc();
    chk("pass_m_aw_valid",   64'(m_aw_valid),   64'd1);
    chk("pass_m_aw_addr",    64'(m_aw_addr),    64'h8000_1000);
    chk("pass_m_aw_user",    64'(m_aw_user),    64'h0002);
    chk("pass_m_aw_payload", 64'(m_aw_payload), 64'hA5A5_0001);
    chk("pass_s_aw_ready",   64'(s_aw_ready),   64'd1);
    s_aw_valid = 1'b0;
    cyc();
    chk("pass_drained", 64'(m_aw_valid), 64'd0);

    // Entry 1 mapped, used by AR
    cfg_write(2'd1, 2'd0, 32'h1000_0000);
    cfg_write(2'd1, 2'd1, 32'h0FFF_FFFF);
    cfg_write(2'd1, 2'd2, 32'h0000_0001);
    s_ar_valid = 1'b1; s_ar_addr = 32'h8012_3456; s_ar_user = 16'h0005; s_ar_payload = 32'h0000_0077;
    cyc();
    chk("map_m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("map_m_ar_addr",  64'(m_ar_addr),  64'h1012_3456);
    chk("map_m_ar_user",  64'(m_ar_user),  64'h0005);
    s_ar_valid = 1'b0;
    cyc();

    // Backpressure: fill both slots, then drain in order
    m_aw_ready = 1'b0;
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_0100; s_aw_user = 16'h0000; s_aw_payload = 32'd1;
    cyc();
    chk("bp_1_s_ready", 64'(s_aw_ready), 64'd1);
    chk("bp_1_m_addr",  64'(m_aw_addr),  64'h100);
    s_aw_addr = 32'h0000_0200; s_aw_payload = 32'd2;
    cyc();
    chk("bp_2_s_ready", 64'(s_aw_ready), 64'd0);
    chk("bp_2_m_addr",  64'(m_aw_addr),  64'h100);
    s_aw_addr = 32'h0000_0300; s_aw_payload = 32'd3;
    cyc();
    chk("bp_hold_s_ready", 64'(s_aw_ready), 64'd0);
    chk("bp_hold_m_valid", 64'(m_aw_valid), 64'd1);
    chk("bp_hold_m_addr",  64'(m_aw_addr),  64'h100);
    m_aw_ready = 1'b1;
    cyc();
    chk("bp_out2_addr",    64'(m_aw_addr),    64'h200);
    chk("bp_out2_payload", 64'(m_aw_payload), 64'd2);
    chk("bp_out2_s_ready", 64'(s_aw_ready),   64'd1);
    cyc();
    chk("bp_out3_addr",    64'(m_aw_addr),    64'h300);
    chk("bp_out3_payload", 64'(m_aw_payload), 64'd3);
    chk("bp_out3_valid",   64'(m_aw_valid),   64'd1);
    s_aw_valid = 1'b0;
    cyc();
    chk("bp_empty", 64'(m_aw_valid), 64'd0);

    // cfg write in the accepting cycle: old BASE applies, next AW sees new BASE
    cfg_wen = 1'b1; cfg_idx = 2'd1; cfg_sel = 2'd0; cfg_wdata = 32'h2000_0000;
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_0040; s_aw_user = 16'h0001;
    cyc();
    cfg_wen = 1'b0;
    chk("cfg_race_old_base", 64'(m_aw_addr), 64'h1000_0040);
    s_aw_addr = 32'h0000_0080;
    cyc();
    chk("cfg_race_new_base", 64'(m_aw_addr), 64'h2000_0080);
    s_aw_valid = 1'b0;
    cyc();

    // Wrapping sum on AR, concurrent unmapped AW
    cfg_write(2'd2, 2'd0, 32'hFFFF_F000);
    cfg_write(2'd2, 2'd1, 32'h0000_FFFF);
    cfg_write(2'd2, 2'd2, 32'h0000_0001);
    s_ar_valid = 1'b1; s_ar_addr = 32'h0000_2000; s_ar_user = 16'h0002;
    s_aw_valid = 1'b1; s_aw_addr = 32'h1234_5678; s_aw_user = 16'h0003;
    cyc();
    chk("wrap_m_ar_addr", 64'(m_ar_addr), 64'h0000_1000);
    chk("dual_m_aw_addr", 64'(m_aw_addr), 64'h1234_5678);
    s_ar_valid = 1'b0; s_aw_valid = 1'b0;
    cyc();

    // Reset while FULL flushes the slice and the table
    m_aw_ready = 1'b0;
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_0111; s_aw_user = 16'h0000;
    cyc();
    s_aw_addr = 32'h0000_0222;
    cyc();
    chk("full_s_ready", 64'(s_aw_ready), 64'd0);
    chk("full_m_valid", 64'(m_aw_valid), 64'd1);
    s_aw_valid = 1'b0;
    reset = 1'b1;
    cyc();
    chk("midrst_m_valid", 64'(m_aw_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_aw_ready), 64'd0);
    chk("midrst_m_addr",  64'(m_aw_addr),  64'd0);
    reset = 1'b0;
    m_aw_ready = 1'b1;
    cyc();
    chk("midrst_after_s_ready", 64'(s_aw_ready), 64'd1);
    chk("midrst_after_m_valid", 64'(m_aw_valid), 64'd0);
    s_aw_valid = 1'b1; s_aw_addr = 32'h8000_0040; s_aw_user = 16'h0001;
    cyc();
    chk("table_reset_passthru", 64'(m_aw_addr), 64'h8000_0040);
    s_aw_valid = 1'b0;
    cyc();

    // 7 ARs, 5 of which hit valid entry 1 (entries 0 and 2 invalid after reset)
`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
    chk("stats_rst_ar", 64'(ar_hit_cnt), 64'd0);
`endif
    cfg_write(2'd1, 2'd2, 32'h0000_0001);
    ar_users[0] = 16'h0001; ar_users[1] = 16'h0001; ar_users[2] = 16'h0000;
    ar_users[3] = 16'h0001; ar_users[4] = 16'h0002; ar_users[5] = 16'h0001;
    ar_users[6] = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      s_ar_valid = 1'b1; s_ar_user = ar_users[i]; s_ar_addr = 32'h0000_1000 + 32'(i);
      cyc();
    end
    s_ar_valid = 1'b0;
    chk("burst_last_ar_addr", 64'(m_ar_addr), 64'h0000_1006);
`ifdef AXI_USER_ADDR_REMAPPER_STATS_EN
    chk("stats_ar_hits", 64'(ar_hit_cnt), 64'd5);
    chk("stats_aw_hits", 64'(aw_hit_cnt), 64'd0);
    cfg_write(2'd0, 2'd3, 32'h0000_0000);
    chk("stats_ar_clear", 64'(ar_hit_cnt), 64'd0);
`endif
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
